// File: rtl/adiabatic_phase_sequencer_if.sv
// Handshake and power-clock phase bus for the adiabatic phase sequencer.
// The master side issues operations and halt; the slave side drives phase codes and capture.
interface adiabatic_phase_sequencer_if #(
  parameter int STAGES      = 7,
  parameter int RAMP_CYCLES = 4,
  parameter int TAG_W       = 4,
  parameter int RAMP_W      = (RAMP_CYCLES > 1) ? $clog2(RAMP_CYCLES) : 1
);
  logic                  op_valid;
  logic [TAG_W-1:0]      op_id;
  logic                  op_ready;
  logic                  halt;
  logic [2*STAGES-1:0]   stage_phase;
  logic [RAMP_W-1:0]     ramp_step;
  logic                  busy;
  logic                  capture;
  logic [TAG_W-1:0]      cap_id;

  modport master (
    output op_valid, op_id, halt,
    input  op_ready, stage_phase, ramp_step, busy, capture, cap_id
  );

  modport slave (
    input  op_valid, op_id, halt,
    output op_ready, stage_phase, ramp_step, busy, capture, cap_id
  );
endinterface

// File: rtl/adiabatic_phase_sequencer.sv
// Four-phase trapezoidal power-clock sequencer for an adiabatic prefix-adder pipeline.
// Each stage runs RISE -> HOLD -> FALL -> IDLE, lagging its predecessor by one phase.
module adiabatic_phase_sequencer #(
  parameter int STAGES      = 7,
  parameter int RAMP_CYCLES = 4,
  parameter int TAG_W       = 4,
  parameter int RAMP_W      = (RAMP_CYCLES > 1) ? $clog2(RAMP_CYCLES) : 1
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  adiabatic_phase_sequencer_if.slave   bus
);

  localparam logic [1:0]        PH_IDLE   = 2'b00;
  localparam logic [1:0]        PH_RISE   = 2'b01;
  localparam logic [1:0]        PH_HOLD   = 2'b10;
  localparam logic [1:0]        PH_FALL   = 2'b11;
  localparam logic [RAMP_W-1:0] RAMP_LAST = RAMP_W'(RAMP_CYCLES - 1);

  logic [1:0]        r_phase     [STAGES];
  logic [TAG_W-1:0]  r_tag       [STAGES];
  logic [1:0]        w_phase_nxt [STAGES];
  logic [TAG_W-1:0]  w_tag_nxt   [STAGES];
  logic [RAMP_W-1:0] r_ramp, w_ramp_nxt;
  logic              r_capture, w_capture_nxt;
  logic [TAG_W-1:0]  r_cap_id, w_cap_id_nxt;
  logic              w_busy, w_tick, w_ready, w_accept;

  // IDLE is never left through this path; stages are launched explicitly.
  function automatic logic [1:0] advance_phase(input logic [1:0] ph);
    logic [1:0] nxt;
    case (ph)
      PH_RISE: nxt = PH_HOLD;
      PH_HOLD: nxt = PH_FALL;
      PH_FALL: nxt = PH_IDLE;
      default: nxt = PH_IDLE;
    endcase
    return nxt;
  endfunction

  // State register: phases, tags, ramp counter and capture pulse.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int k = 0; k < STAGES; k++) begin
        r_phase[k] <= PH_IDLE;
        r_tag[k]   <= '0;
      end
      r_ramp    <= '0;
      r_capture <= 1'b0;
      r_cap_id  <= '0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        r_phase[k] <= w_phase_nxt[k];
        r_tag[k]   <= w_tag_nxt[k];
      end
      r_ramp    <= w_ramp_nxt;
      r_capture <= w_capture_nxt;
      r_cap_id  <= w_cap_id_nxt;
    end
  end

  // Next-state logic: ramp counter, per-stage phase advance on tick, launch on accept.
  always_comb begin
    if (!w_busy) begin
      w_ramp_nxt = '0;
    end else if (bus.halt) begin
      w_ramp_nxt = r_ramp;
    end else if (r_ramp == RAMP_LAST) begin
      w_ramp_nxt = '0;
    end else begin
      w_ramp_nxt = r_ramp + RAMP_W'(1);
    end

    w_phase_nxt[0] = r_phase[0];
    w_tag_nxt[0]   = r_tag[0];
    if (w_accept) begin
      w_phase_nxt[0] = PH_RISE;
      w_tag_nxt[0]   = bus.op_id;
    end else if (w_tick) begin
      w_phase_nxt[0] = advance_phase(r_phase[0]);
    end else begin
      w_phase_nxt[0] = r_phase[0];
    end

    // A stage launches when its predecessor has been rising for a whole phase.
    for (int k = 1; k < STAGES; k++) begin
      w_phase_nxt[k] = r_phase[k];
      w_tag_nxt[k]   = r_tag[k];
      if (!w_tick) begin
        w_phase_nxt[k] = r_phase[k];
      end else if (r_phase[k] != PH_IDLE) begin
        w_phase_nxt[k] = advance_phase(r_phase[k]);
      end else if (r_phase[k-1] == PH_RISE) begin
        w_phase_nxt[k] = PH_RISE;
        w_tag_nxt[k]   = r_tag[k-1];
      end else begin
        w_phase_nxt[k] = PH_IDLE;
      end
    end

    w_capture_nxt = w_tick & (r_phase[STAGES-1] == PH_RISE);
    if (w_capture_nxt) begin
      w_cap_id_nxt = r_tag[STAGES-1];
    end else begin
      w_cap_id_nxt = r_cap_id;
    end
  end

  // Output logic: status, handshake and bus outputs derived from registered state.
  always_comb begin
    w_busy = 1'b0;
    for (int k = 0; k < STAGES; k++) begin
      w_busy = w_busy | (r_phase[k] != PH_IDLE);
    end
    w_tick   = w_busy & ~bus.halt & (r_ramp == RAMP_LAST);
    w_ready  = ~bus.halt & (r_phase[0] == PH_IDLE) & (~w_busy | (r_ramp == RAMP_LAST));
    w_accept = bus.op_valid & w_ready;

    for (int k = 0; k < STAGES; k++) begin
      bus.stage_phase[2*k +: 2] = r_phase[k];
    end
    bus.op_ready  = w_ready;
    bus.ramp_step = r_ramp;
    bus.busy      = w_busy;
    bus.capture   = r_capture;
    bus.cap_id    = r_cap_id;
  end

endmodule

// File: tb/tb_adiabatic_phase_sequencer.sv
// Self-checking bench: a time-based occupancy model checked every cycle, plus directed literal checks.
module tb_adiabatic_phase_sequencer;
  localparam int S  = 7;
  localparam int R  = 4;
  localparam int TW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  adiabatic_phase_sequencer_if #(.STAGES(S), .RAMP_CYCLES(R), .TAG_W(TW)) bus ();
  adiabatic_phase_sequencer_if #(.STAGES(S), .RAMP_CYCLES(1), .TAG_W(TW)) bus1 ();

  adiabatic_phase_sequencer #(.STAGES(S), .RAMP_CYCLES(R), .TAG_W(TW)) dut (
    .i_clk(clk), .i_rst(rst), .bus(bus)
  );
  adiabatic_phase_sequencer #(.STAGES(S), .RAMP_CYCLES(1), .TAG_W(TW)) dut1 (
    .i_clk(clk), .i_rst(rst), .bus(bus1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a virtual clock that advances on every non-halted edge, and the
  // virtual accept time of each operation; phases follow from elapsed time.
  int             m_v;
  int             m_a  [$];
  logic [TW-1:0]  m_id [$];
  logic           m_cap;
  logic [TW-1:0]  m_cap_id;

  function automatic logic [1:0] m_phase(input int k);
    logic [1:0] p;
    int d;
    p = 2'b00;
    foreach (m_a[i]) begin
      d = m_v - m_a[i];
      if (d >= k*R && d < (k+1)*R) p = 2'b01;
      else if (d >= (k+1)*R && d < (k+2)*R) p = 2'b10;
      else if (d >= (k+2)*R && d < (k+3)*R) p = 2'b11;
    end
    return p;
  endfunction

  function automatic logic m_busy();
    logic b;
    b = 1'b0;
    foreach (m_a[i]) if (m_v - m_a[i] < (S+2)*R) b = 1'b1;
    return b;
  endfunction

  function automatic int m_ramp();
    if (!m_busy()) return 0;
    return (m_v - m_a[$]) % R;
  endfunction

  function automatic logic m_ready();
    return !bus.halt && (m_phase(0) == 2'b00) && (!m_busy() || m_ramp() == R-1);
  endfunction

  function automatic void m_clear();
    m_a.delete();
    m_id.delete();
    m_v      = 0;
    m_cap    = 1'b0;
    m_cap_id = '0;
  endfunction

  initial begin
    logic acc;
    logic [2*S-1:0] exp_ph;
    m_clear();
    forever begin
      @(posedge clk);
      if (rst) begin
        m_clear();
      end else begin
        acc   = bus.op_valid && m_ready();
        m_cap = 1'b0;
        if (!bus.halt) begin
          m_v++;
          foreach (m_a[i]) if (m_v - m_a[i] == S*R) begin
            m_cap    = 1'b1;
            m_cap_id = m_id[i];
          end
        end
        if (acc) begin
          m_a.push_back(m_v);
          m_id.push_back(bus.op_id);
        end
      end
      @(negedge clk);
      if (rst) m_clear();
      for (int k = 0; k < S; k++) exp_ph[2*k +: 2] = m_phase(k);
      chk("phase",   32'(bus.stage_phase), 32'(exp_ph));
      chk("ramp",    32'(bus.ramp_step),   32'(m_ramp()));
      chk("busy",    32'(bus.busy),        32'(m_busy()));
      chk("ready",   32'(bus.op_ready),    32'(m_ready()));
      chk("capture", 32'(bus.capture),     32'(m_cap));
      chk("cap_id",  32'(bus.cap_id),      32'(m_cap_id));
    end
  end

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  initial begin
    logic cap_seen;
    bus.op_valid = 1'b0; bus.op_id = '0; bus.halt = 1'b0;
    bus1.op_valid = 1'b0; bus1.op_id = '0; bus1.halt = 1'b0;
    repeat (3) sample();
    rst = 1'b0;
    sample();
    chk("rst_phase",   32'(bus.stage_phase), 32'd0);
    chk("rst_busy",    32'(bus.busy),        32'd0);
    chk("rst_ready",   32'(bus.op_ready),    32'd1);
    chk("rst_capture", 32'(bus.capture),     32'd0);
    chk("rst_ramp",    32'(bus.ramp_step),   32'd0);
    repeat (2) sample();

    // Single operation, tag 5.
    bus.op_valid = 1'b1; bus.op_id = 4'd5;
    @(posedge clk); #1 bus.op_valid = 1'b0;
    for (int n = 0; n <= 40; n++) begin
      sample();
      if (n == 3)  chk("s0_rise_e3",  32'(bus.stage_phase[1:0]),   32'd1);
      if (n == 4)  chk("s0_hold_e4",  32'(bus.stage_phase[1:0]),   32'd2);
      if (n == 7)  chk("s0_hold_e7",  32'(bus.stage_phase[1:0]),   32'd2);
      if (n == 23) chk("s6_idle_e23", 32'(bus.stage_phase[13:12]), 32'd0);
      if (n == 24) chk("s6_rise_e24", 32'(bus.stage_phase[13:12]), 32'd1);
      if (n == 27) chk("cap_e27",     32'(bus.capture),            32'd0);
      if (n == 28) begin
        chk("cap_e28",    32'(bus.capture), 32'd1);
        chk("capid_e28",  32'(bus.cap_id),  32'd5);
        chk("model_cap",  32'(m_cap),       32'd1);
      end
      if (n == 29) chk("cap_e29",  32'(bus.capture), 32'd0);
      if (n == 35) chk("busy_e35", 32'(bus.busy),    32'd1);
      if (n == 36) chk("busy_e36", 32'(bus.busy),    32'd0);
    end

    // Back-to-back with op_valid held: tags 1 then 2.
    bus.op_valid = 1'b1; bus.op_id = 4'd1;
    @(posedge clk); #1 bus.op_id = 4'd2;
    for (int n = 0; n <= 56; n++) begin
      sample();
      if (n <= 14) chk("bb_not_ready", 32'(bus.op_ready), 32'd0);
      if (n == 15) chk("bb_ready_e15", 32'(bus.op_ready), 32'd1);
      if (n == 16) begin
        chk("bb_s0_rise_e16", 32'(bus.stage_phase[1:0]), 32'd1);
        bus.op_valid = 1'b0;
      end
      if (n == 28) begin
        chk("bb_cap1",   32'(bus.capture), 32'd1);
        chk("bb_capid1", 32'(bus.cap_id),  32'd1);
      end
      if (n == 44) begin
        chk("bb_cap2",   32'(bus.capture), 32'd1);
        chk("bb_capid2", 32'(bus.cap_id),  32'd2);
      end
    end

    // Halt for three edges (11, 12, 13).
    bus.op_valid = 1'b1; bus.op_id = 4'd3;
    @(posedge clk); #1 bus.op_valid = 1'b0;
    for (int n = 0; n <= 45; n++) begin
      sample();
      if (n == 10) begin
        chk("h_ramp_e10", 32'(bus.ramp_step), 32'd2);
        bus.halt = 1'b1;
      end
      if (n == 11 || n == 12) begin
        chk("h_ramp_frozen", 32'(bus.ramp_step),  32'd2);
        chk("h_ready_low",   32'(bus.op_ready),   32'd0);
        chk("h_s2_frozen",   32'(bus.stage_phase[5:4]), 32'd1);
      end
      if (n == 13) bus.halt = 1'b0;
      if (n == 30) chk("h_cap_e30",   32'(bus.capture), 32'd0);
      if (n == 31) begin
        chk("h_cap_e31",   32'(bus.capture), 32'd1);
        chk("h_capid_e31", 32'(bus.cap_id),  32'd3);
      end
    end

    // Reset mid-operation.
    bus.op_valid = 1'b1; bus.op_id = 4'd7;
    @(posedge clk); #1 bus.op_valid = 1'b0;
    for (int n = 0; n <= 10; n++) sample();
    #1 rst = 1'b1;
    #1;
    chk("mr_phase", 32'(bus.stage_phase), 32'd0);
    chk("mr_busy",  32'(bus.busy),        32'd0);
    chk("mr_ready", 32'(bus.op_ready),    32'd1);
    sample();
    rst = 1'b0;
    cap_seen = 1'b0;
    for (int n = 0; n < 60; n++) begin
      sample();
      cap_seen = cap_seen | bus.capture;
    end
    chk("mr_no_capture", 32'(cap_seen), 32'd0);

    // Single-cycle phases on the second instance: tags 9 then 10.
    bus1.op_valid = 1'b1; bus1.op_id = 4'd9;
    @(posedge clk); #1 bus1.op_id = 4'd10;
    for (int n = 0; n <= 14; n++) begin
      sample();
      chk("r1_ramp_zero", 32'(bus1.ramp_step), 32'd0);
      if (n <= 2) chk("r1_not_ready", 32'(bus1.op_ready), 32'd0);
      if (n == 3) chk("r1_ready_e3",  32'(bus1.op_ready), 32'd1);
      if (n == 4) begin
        chk("r1_s0_rise_e4", 32'(bus1.stage_phase[1:0]), 32'd1);
        bus1.op_valid = 1'b0;
      end
      if (n == 6) chk("r1_cap_e6", 32'(bus1.capture), 32'd0);
      if (n == 7) begin
        chk("r1_cap_e7",   32'(bus1.capture), 32'd1);
        chk("r1_capid_e7", 32'(bus1.cap_id),  32'd9);
      end
      if (n == 11) begin
        chk("r1_cap_e11",   32'(bus1.capture), 32'd1);
        chk("r1_capid_e11", 32'(bus1.cap_id),  32'd10);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
